// File: rtl/div16.sv
// Multi-cycle restoring divider for the execute stage: one shift-subtract step per cycle,
// sign handled by dividing magnitudes and correcting as the result enters END.
module div16 #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_RUN, S_END} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   quot_q, quot_d;
  logic [DATA_W-1:0]   dvsr_q, dvsr_d;
  logic                qneg_q, qneg_d;
  logic                rneg_q, rneg_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;

  logic [DATA_W:0]     trial, diff;
  logic [DATA_W-1:0]   step_rem, step_quot, mag1, mag2;
  logic                op1_neg, op2_neg, last;

  // Dividend bits shift out of the quotient register into the partial remainder.
  assign trial     = {rem_q, quot_q[DATA_W-1]};
  assign diff      = trial - {1'b0, dvsr_q};
  assign step_rem  = diff[DATA_W] ? trial[DATA_W-1:0] : diff[DATA_W-1:0];
  assign step_quot = {quot_q[DATA_W-2:0], ~diff[DATA_W]};
  assign op1_neg   = signed_div_i & opdata1_i[DATA_W-1];
  assign op2_neg   = signed_div_i & opdata2_i[DATA_W-1];
  assign mag1      = op1_neg ? (~opdata1_i) + DATA_W'(1) : opdata1_i;
  assign mag2      = op2_neg ? (~opdata2_i) + DATA_W'(1) : opdata2_i;
  assign last      = (cnt_q == CNT_W'(DATA_W-1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    dvsr_d   = dvsr_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = '0;
    ready_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i && !annul_i) begin
          dvsr_d  = mag2;
          quot_d  = mag1;
          rem_d   = '0;
          qneg_d  = op1_neg ^ op2_neg;
          rneg_d  = op1_neg;
          cnt_d   = '0;
          state_d = (opdata2_i == '0) ? S_DIVZERO : S_RUN;
        end
      end
      S_DIVZERO: begin
        rem_d   = '0;
        quot_d  = '0;
        state_d = S_END;
      end
      S_RUN: begin
        if (annul_i || !start_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (last) begin
          quot_d  = qneg_q ? (~step_quot) + DATA_W'(1) : step_quot;
          rem_d   = rneg_q ? (~step_rem) + DATA_W'(1) : step_rem;
          cnt_d   = '0;
          state_d = S_END;
        end else begin
          quot_d = step_quot;
          rem_d  = step_rem;
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      S_END: begin
        if (annul_i || !start_i) begin
          state_d = S_IDLE;
        end else begin
          ready_d  = 1'b1;
          result_d = {rem_q, quot_q};
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      dvsr_q   <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      dvsr_q   <= dvsr_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div16.sv
// Directed plus random checks of div16 against an integer-arithmetic reference.
module tb_div16;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [15:0] op1, op2;
  logic        start, annul;
  logic [31:0] result;
  logic        ready;

  int checks = 0;
  int errors = 0;

  div16 dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div),
    .opdata1_i(op1), .opdata2_i(op2), .start_i(start), .annul_i(annul),
    .result_o(result), .ready_o(ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division; SV int '/' and '%' truncate toward zero,
  // so the remainder already carries the dividend's sign.
  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
    logic signed [15:0] as, bs;
    int ia, ib, q, r;
    if (b == 16'h0) return 32'h0;
    if (s) begin
      as = a; bs = b;
      ia = as; ib = bs;
    end else begin
      ia = int'(a); ib = int'(b);
    end
    q = ia / ib;
    r = ia % ib;
    return {r[15:0], q[15:0]};
  endfunction

  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic s);
    @(negedge clk);
    op1 = a; op2 = b; signed_div = s; start = 1'b1; annul = 1'b0;
  endtask

  // Inputs are already driven; the next edge is the start edge.
  task automatic finish(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input int hold, input bit drop);
    logic [31:0] exp;
    int lat;
    exp = model(a, b, s);
    lat = 0;
    @(posedge clk); #1;
    op1 = 16'($urandom); op2 = 16'($urandom); signed_div = 1'($urandom);
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (ready) begin lat = i; break; end
    end
    check({tag, "_latency"}, 32'(lat), (b == 16'h0) ? 32'd2 : 32'd17);
    check({tag, "_result"}, result, exp);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, "_hold"}, {31'h0, ready} ^ 32'(result != exp), 32'd1);
    end
    if (drop) begin
      @(negedge clk); start = 1'b0;
      @(posedge clk); #1;
      check({tag, "_ready_fall"}, {31'h0, ready}, 32'd0);
      check({tag, "_result_clr"}, result, 32'h0);
    end
  endtask

  task automatic divide(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input int hold);
    launch(a, b, s);
    finish(tag, a, b, s, hold, 1'b1);
  endtask

  initial begin
    rst = 1'b1; signed_div = 1'b0; op1 = '0; op2 = '0; start = 1'b0; annul = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", {31'h0, ready}, 32'd0);
    check("reset_result", result, 32'h0);
    @(negedge clk); rst = 1'b0;

    divide("u_100_7", 16'd100, 16'd7, 1'b0, 0);
    check("u_100_7_const", model(16'd100, 16'd7, 1'b0), 32'h0002_000E);
    divide("s_m7_2", 16'hFFF9, 16'h0002, 1'b1, 0);
    divide("s_7_m2", 16'h0007, 16'hFFFE, 1'b1, 0);
    divide("u_dz", 16'h1234, 16'h0000, 1'b0, 0);
    divide("s_dz", 16'h1234, 16'h0000, 1'b1, 0);
    divide("s_min_m1", 16'h8000, 16'hFFFF, 1'b1, 0);
    divide("u_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 0);
    divide("u_3_ffff", 16'h0003, 16'hFFFF, 1'b0, 0);
    divide("u_hold5", 16'd50000, 16'd123, 1'b0, 5);

    // Annul at RUN cycle 8, then immediately restart.
    launch(16'd999, 16'd13, 1'b0);
    @(posedge clk);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      check("annul_run_ready", {31'h0, ready}, 32'd0);
    end
    @(negedge clk); annul = 1'b1;
    @(posedge clk); #1;
    check("annul_ready", {31'h0, ready}, 32'd0);
    @(negedge clk); annul = 1'b0; op1 = 16'hF00D; op2 = 16'hFF83; signed_div = 1'b1;
    finish("annul_restart", 16'hF00D, 16'hFF83, 1'b1, 0, 1'b1);

    // Async reset mid-RUN, then recovery.
    launch(16'd4321, 16'd9, 1'b0);
    repeat (6) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_run_ready", {31'h0, ready}, 32'd0);
    check("rst_run_result", result, 32'h0);
    @(negedge clk); start = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    check("rst_run_idle", {31'h0, ready}, 32'd0);
    divide("post_rst", 16'd4321, 16'd9, 1'b0, 0);

    // Async reset while a result is being held.
    launch(16'h7FFF, 16'h0010, 1'b1);
    finish("rst_end", 16'h7FFF, 16'h0010, 1'b1, 1, 1'b0);
    #3 rst = 1'b1;
    #1;
    check("rst_end_ready", {31'h0, ready}, 32'd0);
    check("rst_end_result", result, 32'h0);
    @(negedge clk); start = 1'b0; rst = 1'b0;

    for (int n = 0; n < 30; n++) begin
      logic [15:0] a, b;
      logic s;
      a = 16'($urandom);
      b = ($urandom_range(0, 9) == 0) ? 16'h0 : 16'($urandom);
      if ($urandom_range(0, 3) == 0) b = 16'($urandom_range(1, 20));
      s = 1'($urandom);
      divide("rand", a, b, s, n % 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
